traffic_light_monitor: RTL



---
 rtl/traffic_light_monitor.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/traffic_light_monitor.sv
// Safety monitor behind the traffic light controller. It forwards healthy lamp samples and latches a fault with flashing red on any violation.
// Latency: 1 cycle from inputs to lamp outputs. Backpressure: none; inputs are sampled every cycle.
// Optional MONITOR_STATS_EN adds a saturating fault_count output.
module traffic_light_monitor #(
    parameter int MIN_GREEN  = 4,
    parameter int MIN_YELLOW = 2,
    parameter int MAX_PHASE  = 64,
    parameter int FLASH_HALF = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] north_in,
    input  logic [2:0] east_in,
    input  logic       clear_fault,
    output logic [2:0] north_out,
    output logic [2:0] east_out,
    output logic       fault,
    output logic [2:0] fault_code
`ifdef MONITOR_STATS_EN
    ,
    output logic [7:0] fault_count
`endif
);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] DARK = 3'b000;

    localparam int PH_MAX = (MIN_GREEN > MIN_YELLOW) ? MIN_GREEN : MIN_YELLOW;
    localparam int PW = $clog2(PH_MAX + 1);
    localparam int SW = $clog2(MAX_PHASE + 1);
    localparam int FW = $clog2(2 * FLASH_HALF);

    localparam logic [PW-1:0] PH_ONE   = PW'(1);
    localparam logic [PW-1:0] PH_SAT   = PW'(PH_MAX);
    localparam logic [PW-1:0] MIN_G_V  = PW'(MIN_GREEN);
    localparam logic [PW-1:0] MIN_Y_V  = PW'(MIN_YELLOW);
    localparam logic [SW-1:0] STALL_MX = SW'(MAX_PHASE);
    localparam logic [FW-1:0] FL_HALF  = FW'(FLASH_HALF);
    localparam logic [FW-1:0] FL_LAST  = FW'(2 * FLASH_HALF - 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t        state_q;
    logic [2:0]    north_q, east_q;
    logic [2:0]    prev_n_q, prev_e_q;
    logic          fault_q;
    logic [2:0]    code_q;
    logic [PW-1:0] ph_n_q, ph_e_q;
    logic [SW-1:0] stall_q;
    logic [FW-1:0] flash_q;
`ifdef MONITOR_STATS_EN
    logic [7:0]    fault_count_q;
`endif

    logic          n_legal, e_legal, n_chg, e_chg, start_ok;
    logic [PW-1:0] ph_n_d, ph_e_d;
    logic [SW-1:0] stall_d;
    logic [FW-1:0] flash_d;
    logic [2:0]    code_d;

    function automatic logic is_legal(input logic [2:0] v);
        return (v == RED) || (v == YEL) || (v == GRN);
    endfunction

    function automatic logic trans_ok(input logic [2:0] p, input logic [2:0] c);
        return ((p == GRN) && (c == YEL)) ||
               ((p == YEL) && (c == RED)) ||
               ((p == RED) && (c == GRN));
    endfunction

    // A direction that leaves green/yellow must have held it long enough.
    function automatic logic too_short(input logic [2:0] p, input logic [2:0] c,
                                       input logic [PW-1:0] cnt);
        return (c != p) && (((p == GRN) && (cnt < MIN_G_V)) ||
                            ((p == YEL) && (cnt < MIN_Y_V)));
    endfunction

    always_comb begin
        n_legal  = is_legal(north_in);
        e_legal  = is_legal(east_in);
        n_chg    = (north_in != prev_n_q);
        e_chg    = (east_in != prev_e_q);
        start_ok = n_legal && e_legal && ((north_in == RED) || (east_in == RED));

        ph_n_d = n_chg ? PH_ONE : ((ph_n_q == PH_SAT) ? ph_n_q : ph_n_q + PH_ONE);
        ph_e_d = e_chg ? PH_ONE : ((ph_e_q == PH_SAT) ? ph_e_q : ph_e_q + PH_ONE);

        stall_d = '0;
        if (!n_chg && !e_chg) begin
            stall_d = (stall_q == STALL_MX) ? stall_q : stall_q + SW'(1);
        end

        flash_d = (flash_q == FL_LAST) ? '0 : flash_q + FW'(1);

        // Ordered so the lowest code wins when several checks fire together.
        code_d = 3'd0;
        if (!n_legal || !e_legal) begin
            code_d = 3'd1;
        end else if ((north_in != RED) && (east_in != RED)) begin
            code_d = 3'd2;
        end else if ((n_chg && !trans_ok(prev_n_q, north_in)) ||
                     (e_chg && !trans_ok(prev_e_q, east_in))) begin
            code_d = 3'd3;
        end else if (too_short(prev_n_q, north_in, ph_n_q) ||
                     too_short(prev_e_q, east_in, ph_e_q)) begin
            code_d = 3'd4;
        end else if (stall_d == STALL_MX) begin
            code_d = 3'd5;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_INIT;
            north_q  <= RED;
            east_q   <= RED;
            prev_n_q <= RED;
            prev_e_q <= RED;
            fault_q  <= 1'b0;
            code_q   <= 3'd0;
            ph_n_q   <= '0;
            ph_e_q   <= '0;
            stall_q  <= '0;
            flash_q  <= '0;
`ifdef MONITOR_STATS_EN
            fault_count_q <= 8'd0;
`endif
        end else begin
            case (state_q)
                ST_INIT: begin
                    north_q <= RED;
                    east_q  <= RED;
                    if (start_ok) begin
                        state_q  <= ST_RUN;
                        prev_n_q <= north_in;
                        prev_e_q <= east_in;
                        north_q  <= north_in;
                        east_q   <= east_in;
                        ph_n_q   <= PH_ONE;
                        ph_e_q   <= PH_ONE;
                        stall_q  <= '0;
                    end
                end
                ST_RUN: begin
                    if (code_d != 3'd0) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                        code_q  <= code_d;
                        north_q <= RED;
                        east_q  <= RED;
                        flash_q <= '0;
`ifdef MONITOR_STATS_EN
                        if (fault_count_q != 8'hFF) begin
                            fault_count_q <= fault_count_q + 8'd1;
                        end
`endif
                    end else begin
                        north_q  <= north_in;
                        east_q   <= east_in;
                        prev_n_q <= north_in;
                        prev_e_q <= east_in;
                        ph_n_q   <= ph_n_d;
                        ph_e_q   <= ph_e_d;
                        stall_q  <= stall_d;
                    end
                end
                ST_FAULT: begin
                    if (clear_fault) begin
                        state_q <= ST_INIT;
                        fault_q <= 1'b0;
                        code_q  <= 3'd0;
                        north_q <= RED;
                        east_q  <= RED;
                        flash_q <= '0;
                    end else begin
                        flash_q <= flash_d;
                        north_q <= (flash_d < FL_HALF) ? RED : DARK;
                        east_q  <= (flash_d < FL_HALF) ? RED : DARK;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    north_q <= RED;
                    east_q  <= RED;
                end
            endcase
        end
    end

    assign north_out  = north_q;
    assign east_out   = east_q;
    assign fault      = fault_q;
    assign fault_code = code_q;
`ifdef MONITOR_STATS_EN
    assign fault_count = fault_count_q;
`endif

endmodule
